// File: rtl/cdb_arbiter_pkg.sv
// Shared core definitions for the common data bus: default widths, source indices, CDB record.
package cdb_arbiter_pkg;

    localparam int CDB_DATA_W = 32;
    localparam int CDB_TAG_W  = 6;

    localparam int SRC_INT  = 0;
    localparam int SRC_MULT = 1;
    localparam int SRC_DIV  = 2;
    localparam int SRC_LS   = 3;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_TAG_W-1:0]  tag;
        logic                  valid;
        logic                  branch;
        logic                  branch_taken;
    } cdb_rec_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result interface between the execution queues (master) and the CDB arbiter (slave).
interface cdb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC-1:0]        src_branch;
    logic [NUM_SRC-1:0]        src_branch_taken;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      flush;
    logic [DATA_W-1:0]         cdb_data;
    logic [TAG_W-1:0]          cdb_tag;
    logic                      cdb_valid;
    logic                      cdb_branch;
    logic                      cdb_branch_taken;

    modport master (
        output src_valid, src_data, src_tag, src_branch, src_branch_taken, flush,
        input  src_ready, cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken
    );

    modport slave (
        input  src_valid, src_data, src_tag, src_branch, src_branch_taken, flush,
        output src_ready, cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken
    );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after i_ptr, wrapping at N-1.
// Zero latency; o_gnt is one-hot, or zero when nothing requests.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);
    logic           w_found;
    logic [PTR_W:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(N)) begin
                w_idx = w_idx - (PTR_W+1)'(N);
            end
            if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
                o_gnt[w_idx[PTR_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one completed result per cycle and broadcasts it registered (latency 1).
// No CDB backpressure; flush forces no grant. CDB_ARB_FIXED_PRIO_EN selects lowest-index priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int TAG_W   = CDB_TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_gnt;
    cdb_rec_t           w_next;
    cdb_rec_t           r_cdb;

    // Reset and flush both suppress the grant so no source believes it was consumed.
    assign w_req         = (rst && !bus.flush) ? bus.src_valid : '0;
    assign bus.src_ready = w_gnt;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign w_gnt = w_req & (~w_req + NUM_SRC'(1));
`else
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_g;

    rr_arbiter #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_g = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_gnt[i]) begin
                w_g = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (|w_gnt) begin
            r_ptr <= (w_g == PTR_W'(NUM_SRC-1)) ? '0 : w_g + PTR_W'(1);
        end
    end
`endif

    // One-hot grant makes an OR-mux sufficient; an empty cycle yields an all-zero record.
    always_comb begin
        w_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_gnt[i]) begin
                w_next.data         = bus.src_data[i*DATA_W +: DATA_W];
                w_next.tag          = bus.src_tag[i*TAG_W +: TAG_W];
                w_next.valid        = 1'b1;
                w_next.branch       = bus.src_branch[i];
                w_next.branch_taken = bus.src_branch[i] & bus.src_branch_taken[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb <= '0;
        end else begin
            r_cdb <= w_next;
        end
    end

    assign bus.cdb_data         = r_cdb.data;
    assign bus.cdb_tag          = r_cdb.tag;
    assign bus.cdb_valid        = r_cdb.valid;
    assign bus.cdb_branch       = r_cdb.branch;
    assign bus.cdb_branch_taken = r_cdb.branch_taken;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, rotation, idle, wrap, branch flags, flush, async reset.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

`ifdef CDB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst;

    cdb_arbiter_if #(.NUM_SRC(4), .DATA_W(32), .TAG_W(6)) bus ();

    cdb_arbiter #(.NUM_SRC(4), .DATA_W(32), .TAG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    logic [31:0] d  [4];
    logic [5:0]  t  [4];
    logic [3:0]  br;
    logic [3:0]  bt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld);
        bus.src_valid = vld;
        for (int i = 0; i < 4; i++) begin
            bus.src_data[i*32 +: 32] = d[i];
            bus.src_tag[i*6 +: 6]    = t[i];
        end
        bus.src_branch       = br;
        bus.src_branch_taken = bt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cdb(input string tag, input int src);
        chk({tag, "_vld"},  64'(bus.cdb_valid), 64'd1);
        chk({tag, "_tag"},  64'(bus.cdb_tag),   64'(t[src]));
        chk({tag, "_data"}, 64'(bus.cdb_data),  64'(d[src]));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_vld"},  64'(bus.cdb_valid),        64'd0);
        chk({tag, "_data"}, 64'(bus.cdb_data),         64'd0);
        chk({tag, "_tag"},  64'(bus.cdb_tag),          64'd0);
        chk({tag, "_br"},   64'(bus.cdb_branch),       64'd0);
        chk({tag, "_bt"},   64'(bus.cdb_branch_taken), 64'd0);
    endtask

    initial begin
        int eg;
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = 32'hA000_0000 + 32'(i * 16 + 5);
            t[i] = 6'h10 + 6'(i);
        end
        br        = 4'b0000;
        bt        = 4'b0000;
        bus.flush = 1'b0;
        rst       = 1'b1;
        drive(4'b1111);
        #2 rst = 1'b0;

        // Reset held with every source valid.
        tick();
        tick();
        @(negedge clk);
        chk("rst_rdy", 64'(bus.src_ready), 64'd0);
        chk_empty("rst_cdb");

        // Release and rotate through all sources for 8 back-to-back grants.
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            eg = FIXED ? SRC_INT : (k % 4);
            @(negedge clk);
            chk("rr_rdy", 64'(bus.src_ready), 64'(4'b0001 << eg));
            tick();
            chk_cdb("rr_cdb", eg);
        end

        // Idle cycle clears the CDB completely.
        drive(4'b0000);
        @(negedge clk);
        chk("idle_rdy", 64'(bus.src_ready), 64'd0);
        tick();
        chk_empty("idle_cdb");

        // Single source: load/store queue alone.
        d[SRC_LS] = 32'hDEADBEEF;
        t[SRC_LS] = 6'h2A;
        drive(4'b1000);
        @(negedge clk);
        chk("one_rdy", 64'(bus.src_ready), 64'h8);
        tick();
        chk_cdb("one_cdb", SRC_LS);

        // Wrap: source 3 granted, then 0 and 2 contend.
        drive(4'b1000);
        @(negedge clk);
        chk("wrap3_rdy", 64'(bus.src_ready), 64'h8);
        tick();
        drive(4'b0101);
        @(negedge clk);
        chk("wrap0_rdy", 64'(bus.src_ready), 64'h1);
        tick();
        chk_cdb("wrap0_cdb", SRC_INT);
        drive(4'b0100);
        @(negedge clk);
        chk("wrap2_rdy", 64'(bus.src_ready), 64'h4);
        tick();
        chk_cdb("wrap2_cdb", SRC_DIV);

        // Branch flags from the multiplier queue.
        br = 4'b0010;
        bt = 4'b0010;
        drive(4'b0010);
        @(negedge clk);
        chk("br_rdy", 64'(bus.src_ready), 64'h2);
        tick();
        chk("br_flag",  64'(bus.cdb_branch),       64'd1);
        chk("br_taken", 64'(bus.cdb_branch_taken), 64'd1);
        br = 4'b0000;
        drive(4'b0010);
        tick();
        chk("nbr_flag",  64'(bus.cdb_branch),       64'd0);
        chk("nbr_taken", 64'(bus.cdb_branch_taken), 64'd0);
        chk("nbr_vld",   64'(bus.cdb_valid),        64'd1);
        bt = 4'b0000;

        // Flush: pointer sits at 2 here; the flush cycle grants nothing and holds it.
        drive(4'b1111);
        eg = FIXED ? SRC_INT : SRC_DIV;
        @(negedge clk);
        chk("pre_fl_rdy", 64'(bus.src_ready), 64'(4'b0001 << eg));
        tick();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl_rdy", 64'(bus.src_ready), 64'd0);
        chk_cdb("fl_cur", eg);
        tick();
        bus.flush = 1'b0;
        chk_empty("fl_next");
        eg = FIXED ? SRC_INT : SRC_LS;
        @(negedge clk);
        chk("post_fl_rdy", 64'(bus.src_ready), 64'(4'b0001 << eg));
        tick();
        chk_cdb("post_fl_cdb", eg);

        // Asynchronous reset drops a registered word between clock edges.
        #1 rst = 1'b0;
        #1;
        chk("arst_vld", 64'(bus.cdb_valid), 64'd0);
        chk("arst_rdy", 64'(bus.src_ready), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common data bus (CDB) arbiter for the out-of-order core. It collects completed results from the execution queues (integer, multiply, divide, load/store) and grants exactly one of them per cycle. The winner is registered and broadcast on the CDB to the reservation stations, register status table and ROB. It is the consumer end of the `cdb_*` result interface that every execution queue drives.

## Interface
- `NUM_SRC`, default 4: number of result sources. Index 0 int, 1 mult, 2 div, 3 ls.
- `DATA_W`, default 32: result data width.
- `TAG_W`, default 6: ROB/physical tag width.
- `clk  in  1`: single clock; all state on rising edge.
- `rst  in  1`: asynchronous, active-low reset (asserted when 0).
- `src_valid  in  NUM_SRC`: source i holds a completed result.
- `src_data  in  NUM_SRC*DATA_W`: packed result data; source i at `[i*DATA_W +: DATA_W]`.
- `src_tag  in  NUM_SRC*TAG_W`: packed destination tags.
- `src_branch  in  NUM_SRC`: result belongs to a branch.
- `src_branch_taken  in  NUM_SRC`: branch resolved taken; meaningful only with `src_branch`.
- `src_ready  out  NUM_SRC`: one-hot-or-zero grant, combinational.
- `flush  in  1`: pipeline flush (mispredict recovery).
- `cdb_data  out  DATA_W`, `cdb_tag  out  TAG_W`: broadcast result.
- `cdb_valid  out  1`: broadcast valid.
- `cdb_branch  out  1`, `cdb_branch_taken  out  1`: branch resolution flags.

## Operation
- Handshake: a transfer occurs for source i when `src_valid[i] && src_ready[i]`. A source holds valid, data, tag and flags stable until granted. A source never waits for ready before asserting valid.
- `src_ready` is combinational from `src_valid`, `flush` and the priority pointer `ptr` (log2(NUM_SRC) bits). At most one bit is set.
- Round-robin: search starts at `ptr` and wraps at NUM_SRC-1 to 0. The first valid source wins.
- After a grant to source g, `ptr <= (g+1) mod NUM_SRC`; `NUM_SRC-1` wraps to 0. With no grant, `ptr` holds.
- No valid sources: no grant. Next cycle `cdb_valid=0` and `cdb_data`, `cdb_tag`, `cdb_branch`, `cdb_branch_taken` are all 0.
- `cdb_branch_taken` is registered as `src_branch_taken[g] & src_branch[g]`.
- `flush=1`: `src_ready` is forced to 0. The next-cycle CDB is empty (all fields 0) and `ptr` holds. A CDB word already registered in the flush cycle still broadcasts that cycle.
- There is no backpressure from the CDB; the arbiter sustains one grant per cycle.

## Timing
- Grant in cycle N: `cdb_*` is valid for exactly cycle N+1. Latency is 1 and throughput is 1 per cycle.
- Back-to-back grants produce consecutive `cdb_valid` cycles with no bubble.
- Reset (`rst=0`, asynchronous): `cdb_valid`, `cdb_data`, `cdb_tag`, `cdb_branch`, `cdb_branch_taken` go to 0 and `ptr` goes to 0. `src_ready` is 0 while reset is asserted.
- Reset mid-operation: a registered but not yet broadcast result is dropped. Sources granted in that cycle are not re-offered; recovery is handled by a global flush.
- First rising edge after reset deassertion: normal arbitration with `ptr=0`.

## Configuration
- `CDB_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins (int > mult > div > ls). `ptr` is not implemented.
- Not defined: round-robin as above.
- Latency, flush and reset behaviour are identical in both modes.

## Structure
- The shared core package holds `DATA_W`/`TAG_W` defaults, source index constants (`SRC_INT`=0, `SRC_MULT`=1, `SRC_DIV`=2, `SRC_LS`=3) and the CDB record typedef (data, tag, valid, branch, branch_taken).
- One sub-module: `rr_arbiter`, a parameterised combinational round-robin grant generator taking `req` and `ptr` and producing a one-hot `gnt`. The fixed-priority mode bypasses it.
- Output register, pointer update and flush gating live in `cdb_arbiter`.

## Test plan
- Reset: hold `rst=0` with all `src_valid=1`. Require all `cdb_*`=0 and `src_ready`=0. Release `rst`; with `ptr=0`, source 0 is granted.
- Single source: `src_valid=4'b1000`, tag 6'h2A, data 32'hDEADBEEF. Require `src_ready=4'b1000` in the same cycle; next cycle `cdb_valid=1`, `cdb_tag=6'h2A`, `cdb_data=32'hDEADBEEF`.
- Round-robin fairness: all four valid for 8 cycles. Require grant order 0,1,2,3,0,1,2,3 and 8 consecutive `cdb_valid` cycles. With `CDB_ARB_FIXED_PRIO_EN`, require source 0 every cycle.
- Wrap-around: grant source 3, then sources 0 and 2 are valid. Require source 0 first, then source 2.
- Branch: source 1 has `src_branch=1`, `src_branch_taken=1`. Require next-cycle `cdb_branch=1`, `cdb_branch_taken=1`. With `src_branch=0`, `src_branch_taken=1`, require `cdb_branch_taken=0`.
- Flush: all valid, then assert `flush` for 1 cycle. Require `src_ready=0` that cycle and `cdb_valid=0` the next. `ptr` is unchanged, so the grant after the flush goes to the same source that would have won.
